// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: sequencer states, default widths and grid size.
package snake_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT      = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_PAUSED    = 3'd4,
    ST_OVER      = 3'd5
  } seq_state_t;

  localparam int unsigned SCORE_W_DEFAULT = 10;
  localparam int unsigned LEVEL_W_DEFAULT = 4;

  localparam int unsigned GRID_COLS = 32;
  localparam int unsigned GRID_ROWS = 24;

endpackage

// File: rtl/snake_sequencer_if.sv
// Step handshake between the game sequencer (master) and the snake field (slave).
interface snake_sequencer_if;
  logic field_init;
  logic step_req;
  logic step_ack;
  logic collision;
  logic ate_food;

  modport master (
    output field_init,
    output step_req,
    input  step_ack,
    input  collision,
    input  ate_food
  );

  modport slave (
    input  field_init,
    input  step_req,
    output step_ack,
    output collision,
    output ate_food
  );
endinterface

// File: rtl/period_counter.sv
// Move-tick counter: counts 0..period-1 while enabled and flags the wrap cycle.
module period_counter #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic             wrap
);

  logic [CNT_W-1:0] count;

  // >= keeps the wrap alive if the period shrinks below the current count
  assign wrap = en && (count >= period - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/snake_sequencer.sv
// Game-flow controller: state machine, move tick, step handshake, score and level.
// Optional level-based speedup is enabled by defining SNAKE_SPEEDUP_EN.
module snake_sequencer
  import snake_pkg::*;
#(
  parameter int unsigned BASE_PERIOD    = 12000000,
  parameter int unsigned MIN_PERIOD     = 2000000,
  parameter int unsigned PERIOD_DEC     = 1000000,
  parameter int unsigned FOOD_PER_LEVEL = 5,
  parameter int unsigned SCORE_W        = SCORE_W_DEFAULT,
  parameter int unsigned LEVEL_W        = LEVEL_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                pause,
  snake_sequencer_if.master   step,
  output logic                running,
  output logic                game_over,
  output logic [SCORE_W-1:0]  score,
  output logic [LEVEL_W-1:0]  level
);

  localparam int unsigned CNT_W  = $clog2(BASE_PERIOD + 1);
  localparam int unsigned PROD_W = CNT_W + LEVEL_W;

  seq_state_t       state;
  logic             pend_pause;
  logic [CNT_W-1:0] period;
  logic             cnt_en;
  logic             cnt_clr;
  logic             wrap;
  logic             eat_ev;

  function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Clamp before subtracting so the period never underflows below MIN_PERIOD
  function automatic logic [CNT_W-1:0] calc_period(input logic [LEVEL_W-1:0] lvl);
    logic [PROD_W-1:0] dec;
    dec = PROD_W'(lvl) * PROD_W'(PERIOD_DEC);
    if (dec >= PROD_W'(BASE_PERIOD - MIN_PERIOD))
      return CNT_W'(MIN_PERIOD);
    return CNT_W'(PROD_W'(BASE_PERIOD) - dec);
  endfunction

  assign cnt_clr = (state == ST_INIT);
  assign cnt_en  = !start && (((state == ST_RUN) && !pause) || (state == ST_STEP_WAIT));
  assign eat_ev  = (state == ST_STEP_WAIT) && !start && step.step_ack &&
                   !step.collision && step.ate_food;

  period_counter #(.CNT_W(CNT_W)) u_period_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .period (period),
    .wrap   (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      pend_pause      <= 1'b0;
      step.field_init <= 1'b0;
      step.step_req   <= 1'b0;
      running         <= 1'b0;
      game_over       <= 1'b0;
    end else begin
      step.field_init <= 1'b0;
      if (start) begin
        state           <= ST_INIT;
        step.field_init <= 1'b1;
        step.step_req   <= 1'b0;
        running         <= 1'b0;
        game_over       <= 1'b0;
      end else begin
        case (state)
          ST_INIT: begin
            pend_pause <= 1'b0;
            running    <= 1'b1;
            state      <= ST_RUN;
          end
          ST_RUN: begin
            if (pause) begin
              running <= 1'b0;
              state   <= ST_PAUSED;
            end else if (wrap) begin
              step.step_req <= 1'b1;
              state         <= ST_STEP_WAIT;
            end
          end
          ST_STEP_WAIT: begin
            // A wrap while still waiting is deliberately dropped
            if (step.step_ack) begin
              step.step_req <= 1'b0;
              if (step.collision) begin
                pend_pause <= 1'b0;
                running    <= 1'b0;
                game_over  <= 1'b1;
                state      <= ST_OVER;
              end else if (pend_pause || pause) begin
                pend_pause <= 1'b0;
                running    <= 1'b0;
                state      <= ST_PAUSED;
              end else begin
                state <= ST_RUN;
              end
            end else if (pause) begin
              pend_pause <= 1'b1;
            end
          end
          ST_PAUSED: begin
            if (pause) begin
              running <= 1'b1;
              state   <= ST_RUN;
            end
          end
          ST_IDLE, ST_OVER: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      score <= '0;
    else if (state == ST_INIT)
      score <= '0;
    else if (eat_ev)
      score <= sat_inc_score(score);
  end

`ifdef SNAKE_SPEEDUP_EN
  localparam int unsigned FOOD_W = $clog2(FOOD_PER_LEVEL + 1);

  logic [FOOD_W-1:0] food_cnt;

  function automatic logic [LEVEL_W-1:0] sat_inc_level(input logic [LEVEL_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level    <= '0;
      food_cnt <= '0;
      period   <= CNT_W'(BASE_PERIOD);
    end else begin
      period <= calc_period(level);
      if (state == ST_INIT) begin
        level    <= '0;
        food_cnt <= '0;
      end else if (eat_ev) begin
        if (food_cnt == FOOD_W'(FOOD_PER_LEVEL - 1)) begin
          food_cnt <= '0;
          level    <= sat_inc_level(level);
        end else begin
          food_cnt <= food_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign level  = '0;
  assign period = CNT_W'(BASE_PERIOD);
`endif

endmodule

// File: tb/tb_snake_sequencer.sv
// Directed bench for snake_sequencer; expectations adapt to SNAKE_SPEEDUP_EN.
module tb_snake_sequencer;
  import snake_pkg::*;

  localparam int BASE = 8;
  localparam int MINP = 4;
  localparam int DEC  = 2;
  localparam int FPL  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       pause;
  logic       running;
  logic       game_over;
  logic [9:0] score;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;

  snake_sequencer_if step_bus ();

  snake_sequencer #(
    .BASE_PERIOD    (BASE),
    .MIN_PERIOD     (MINP),
    .PERIOD_DEC     (DEC),
    .FOOD_PER_LEVEL (FPL),
    .SCORE_W        (10),
    .LEVEL_W        (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pause     (pause),
    .step      (step_bus),
    .running   (running),
    .game_over (game_over),
    .score     (score),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    tick();
    pause = 1'b0;
  endtask

  task automatic do_ack(input logic col, input logic food);
    step_bus.step_ack  = 1'b1;
    step_bus.collision = col;
    step_bus.ate_food  = food;
    tick();
    step_bus.step_ack  = 1'b0;
    step_bus.collision = 1'b0;
    step_bus.ate_food  = 1'b0;
  endtask

  // Ticks until step_req is seen high; returns ticks taken, capped at 64
  task automatic wait_req(output int n);
    n = 0;
    while (!step_bus.step_req && n < 64) begin
      tick();
      n++;
    end
  endtask

  int n;
  int ivl [1:8];
  int exp_ivl [1:8];
  int exp_lvl8;
  logic seen;

  initial begin
`ifdef SNAKE_SPEEDUP_EN
    exp_ivl  = '{8, 6, 6, 0, 4, 0, 4, 0};
    exp_lvl8 = 4;
`else
    exp_ivl  = '{8, 8, 8, 0, 8, 0, 8, 0};
    exp_lvl8 = 0;
`endif
    rst_n = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    step_bus.step_ack  = 1'b0;
    step_bus.collision = 1'b0;
    step_bus.ate_food  = 1'b0;
    tick();
    tick();
    chk("rst_field_init", step_bus.field_init, 0);
    chk("rst_step_req", step_bus.step_req, 0);
    chk("rst_running", running, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_score", score, 0);
    chk("rst_level", level, 0);
    rst_n = 1'b1;
    tick();
    pulse_pause();
    tick();
    chk("idle_pause_ignored", running, 0);

    // start at cycle 0
    pulse_start();
    chk("c1_field_init", step_bus.field_init, 1);
    chk("c1_running", running, 0);
    tick();
    chk("c2_running", running, 1);
    chk("c2_field_init", step_bus.field_init, 0);
    repeat (7) tick();
    chk("c9_step_req", step_bus.step_req, 0);
    tick();
    chk("c10_step_req", step_bus.step_req, 1);
    tick();
    chk("c11_step_req_held", step_bus.step_req, 1);
    do_ack(1'b0, 1'b0);
    chk("c13_step_req", step_bus.step_req, 0);
    chk("c13_running", running, 1);

    // eight foods; ack always two cycles after the request rises
    pulse_start();
    tick();
    wait_req(n);
    chk("first_period", n, 8);
    for (int k = 1; k <= 8; k++) begin
      tick();
      tick();
      do_ack(1'b0, 1'b1);
      wait_req(n);
      ivl[k] = n + 3;
    end
    chk("ivl_lvl0", ivl[1], exp_ivl[1]);
    chk("ivl_lvl1", ivl[3], exp_ivl[3]);
    chk("ivl_lvl2", ivl[5], exp_ivl[5]);
    chk("ivl_lvl3", ivl[7], exp_ivl[7]);
    chk("score_8", score, 8);
    chk("level_8", level, exp_lvl8);

    // collision wins over food
    tick();
    do_ack(1'b1, 1'b1);
    chk("over_game_over", game_over, 1);
    chk("over_running", running, 0);
    chk("over_step_req", step_bus.step_req, 0);
    chk("over_score", score, 8);
    chk("over_level", level, exp_lvl8);
    pulse_pause();
    tick();
    chk("over_pause_ignored", game_over, 1);
    chk("over_pause_running", running, 0);
    pulse_start();
    chk("restart_field_init", step_bus.field_init, 1);
    chk("restart_game_over", game_over, 0);
    tick();
    chk("restart_score", score, 0);
    chk("restart_level", level, 0);
    chk("restart_running", running, 1);

    // pause during STEP_WAIT, ack three cycles later
    wait_req(n);
    chk("restart_period", n, 8);
    pulse_pause();
    tick();
    tick();
    do_ack(1'b0, 1'b0);
    chk("pend_paused_running", running, 0);
    chk("pend_paused_req", step_bus.step_req, 0);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (step_bus.step_req) seen = 1'b1;
    end
    chk("paused_no_req", seen, 0);
    pulse_pause();
    chk("resume_running", running, 1);
    wait_req(n);
    chk("resume_held_count", n, 4);

    // start and pause together in RUN
    tick();
    do_ack(1'b0, 1'b0);
    start = 1'b1;
    pause = 1'b1;
    tick();
    start = 1'b0;
    pause = 1'b0;
    chk("sp_run_field_init", step_bus.field_init, 1);
    chk("sp_run_running", running, 0);
    tick();
    chk("sp_run_running2", running, 1);
    wait_req(n);
    chk("sp_run_period", n, 8);

    // pending pause then start+pause: pending must be cleared
    pulse_pause();
    start = 1'b1;
    pause = 1'b1;
    tick();
    start = 1'b0;
    pause = 1'b0;
    chk("sp_wait_field_init", step_bus.field_init, 1);
    chk("sp_wait_step_req", step_bus.step_req, 0);
    tick();
    wait_req(n);
    chk("sp_wait_period", n, 8);
    tick();
    do_ack(1'b0, 1'b0);
    chk("pend_cleared_running", running, 1);

    // asynchronous reset mid-handshake
    wait_req(n);
    chk("pre_rst_req", step_bus.step_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_step_req", step_bus.step_req, 0);
    chk("arst_running", running, 0);
    chk("arst_field_init", step_bus.field_init, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_ack(1'b0, 1'b1);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (step_bus.step_req || running || game_over) seen = 1'b1;
    end
    chk("post_rst_idle", seen, 0);
    chk("post_rst_score", score, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_sequencer.md
# snake_sequencer

Game-flow controller for the snake game. It owns the game state machine (idle, running, paused, game over) and generates the move tick with a programmable, level-dependent period. It issues one step request per tick to the snake field over a req/ack handshake and keeps score and level. It sits between the keyboard command decoder (start/pause pulses) and the snake field, replacing the free-running tick and the `is_running` flop in the top level.

## Interface
- `BASE_PERIOD`, 12000000: tick period in clocks at level 0.
- `MIN_PERIOD`, 2000000: floor on the tick period.
- `PERIOD_DEC`, 1000000: period reduction per level.
- `FOOD_PER_LEVEL`, 5: foods eaten per level increment (≥1).
- `SCORE_W`, 10: score width.
- `LEVEL_W`, 4: level width.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse to start or restart a game.
- `pause` in 1: one-cycle pulse to toggle pause.
- `step_ack` in 1: field finished the requested step; one-cycle pulse.
- `collision` in 1: valid with `step_ack`; the snake hit a wall or itself.
- `ate_food` in 1: valid with `step_ack`; the head reached food.
- `field_init` out 1: one-cycle pulse that clears and seeds the field.
- `step_req` out 1: step request, held until `step_ack`.
- `running` out 1: high in RUN and STEP_WAIT.
- `game_over` out 1: high in OVER.
- `score` out SCORE_W: foods eaten this game, saturating.
- `level` out LEVEL_W: current speed level, saturating.

## Operation
States: IDLE, INIT, RUN, STEP_WAIT, PAUSED, OVER. Reset enters IDLE.

- **IDLE**
  - `start` → INIT.
  - `pause` is ignored.
- **INIT** (one cycle)
  - `field_init`=1.
  - Clears score, level, food counter, tick counter and pending-pause.
  - → RUN.
- **RUN**
  - Tick counter increments each cycle.
  - At `period-1`: counter → 0, `step_req`←1, → STEP_WAIT.
  - `pause` → PAUSED, counter holds its value.
  - `start` → INIT.
- **STEP_WAIT**
  - Tick counter counts on, so the tick rate is not stretched by ack latency.
  - `pause` sets pending-pause.
  - `start` → INIT and drops `step_req`.
  - On `step_ack`:
    - `step_req`←0.
    - If `collision` → OVER; `ate_food` is ignored.
    - Else if `ate_food`: score+1, saturating at all-ones. Food counter +1; when it reaches `FOOD_PER_LEVEL`, it resets to 0 and level+1, saturating.
    - Then → PAUSED if pending-pause (cleared), else → RUN.
  - If the counter wraps again while still waiting, no second request is issued; the tick is dropped.
- **PAUSED**
  - `pause` → RUN, resuming the counter.
  - `start` → INIT.
- **OVER**
  - Score and level hold.
  - `start` → INIT.
  - `pause` is ignored.

Rules that apply in every state:
- `start` and `pause` in the same cycle: `start` wins.
- `step_ack` outside STEP_WAIT is ignored.

Period arithmetic:
- `period = max(MIN_PERIOD, BASE_PERIOD − level·PERIOD_DEC)`.
- Compute in `$clog2(BASE_PERIOD+1)`+LEVEL_W bits with no underflow: clamp when `level·PERIOD_DEC ≥ BASE_PERIOD − MIN_PERIOD`.
- The period is registered and updated on the cycle after a level change.

## Timing
- All outputs are registered.
- Reset values: `field_init`=0, `step_req`=0, `running`=0, `game_over`=0, `score`=0, `level`=0.
- `start` in cycle N: `field_init`=1 in N+1, `running`=1 in N+2.
- First `step_req` rises `period` cycles after entering RUN.
- `step_ack` in cycle M: `step_req`=0, score/level updated and the new state visible in M+1.
- Asynchronous reset mid-handshake drops `step_req` immediately. Without a subsequent `start`, no further request is issued.

## Configuration
- Macro `SNAKE_SPEEDUP_EN`.
  - Defined: level-based period reduction as described above.
  - Undefined:
    - `level` is tied to 0.
    - Period is a constant `BASE_PERIOD`.
    - Food counter logic is removed.
    - Score still counts.

## Structure
- Shared package `snake_pkg`:
  - state enum `seq_state_t`
  - `SCORE_W` and `LEVEL_W` defaults
  - grid-size constants shared with the field
- Sub-module `period_counter`:
  - load-able period
  - enable input
  - synchronous clear
  - one-cycle `wrap` output
  - the FSM instantiates one.

## Test plan
Bench parameters: `BASE_PERIOD`=8, `MIN_PERIOD`=4, `PERIOD_DEC`=2, `FOOD_PER_LEVEL`=2.
- Reset, then `start` at cycle 0 → `field_init` at cycle 1, `running` at 2, `step_req` rises at cycle 10; ack at 12 → `step_req`=0 at 13.
- Eight acks with `ate_food`=1 → score 8, level 4; period sequence 8, 6, 4, 4.
- Ack with `collision`=1 and `ate_food`=1 → OVER, `running`=0, `game_over`=1, score unchanged; later `pause` has no effect; `start` → score 0.
- `pause` during STEP_WAIT, ack 3 cycles later → PAUSED. Second `pause` → RUN; the counter resumes from its held value, not zero.
- `start` and `pause` in the same cycle while in RUN → INIT (`field_init` pulse), pending-pause cleared.
- `rst_n` low while `step_req`=1 → all outputs 0 asynchronously; a spurious `step_ack` after release is ignored and the block stays in IDLE.
